// File: rtl/gardner_ted.sv
// gardner_ted: Gardner timing-error detector with optional PI loop filter.
// On each accepted on-time strobe the detector combines the previous on-time
// sample, the midpoint sample (MID_DELAY clocks after the previous strobe) and
// the current on-time sample into a saturated Gardner error, then filters it
// and emits the negated, saturated correction word.
//
// Build option: define GARDNER_TED_LOOP_FILTER_EN to include the proportional +
// saturating-integral loop filter; otherwise error_n = sat(-e).
//
// Ports:
//   clk          32.768 MHz clock, posedge logic
//   rst_n        asynchronous active-low reset
//   I_32M/Q_32M  signed I/Q samples, one per clk
//   strobe       one-cycle on-time marker from the timing corrector
//   error_n      signed negated filtered timing error, held between updates
//   error_valid  one-cycle pulse, 3 clk after the accepted strobe
module gardner_ted #(
    parameter int WIDTH     = 16,
    parameter int MID_DELAY = 16,
    parameter int KP_SHIFT  = 1,
    parameter int KI_SHIFT  = 4,
    parameter int ACC_EXT   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] I_32M,
    input  logic signed [WIDTH-1:0] Q_32M,
    input  logic                    strobe,
    output logic signed [WIDTH-1:0] error_n,
    output logic                    error_valid
);
    localparam int CW = $clog2(MID_DELAY + 1);
    localparam int PW = 2 * WIDTH + 2;
    // cnt is cleared on the strobe edge, so the cycle sampled MID_DELAY edges
    // later still shows MID_DELAY-1.
    localparam logic [CW-1:0] MID_LAST = CW'(MID_DELAY - 1);
    localparam logic signed [PW-1:0] LIM_P = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    if (MID_DELAY < 1 || KP_SHIFT < 0 || KI_SHIFT < 0 || ACC_EXT < 0) begin : g_bad_cfg
        $error("gardner_ted: invalid parameter set");
    end

    typedef enum logic [1:0] {S_INIT, S_MID, S_ON} state_t;
    state_t state, state_next;

    logic [CW-1:0]           cnt;
    logic                    cap_prev, cap_mid, launch, cnt_clr, cnt_inc;
    logic signed [WIDTH-1:0] prev_i, prev_q, mid_i, mid_q;
    logic signed [WIDTH-1:0] lp_i, lp_q, cur_i, cur_q;
    logic signed [WIDTH:0]   d_i, d_q;
    logic signed [WIDTH-1:0] e_reg, e_next;
    logic                    v0, v1, v2;
    logic signed [PW-1:0]    mi_x, mq_x, di_x, dq_x, prod, e_wide;

    function automatic logic signed [PW-1:0] clamp_p(input logic signed [PW-1:0] x);
        if (x > LIM_P)
            return LIM_P;
        else if (x < -LIM_P)
            return -LIM_P;
        else
            return x;
    endfunction

    always_comb begin
        state_next = state;
        cap_prev   = 1'b0;
        cap_mid    = 1'b0;
        launch     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            S_INIT: begin
                if (strobe) begin
                    cap_prev   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_MID;
                end
            end
            S_MID: begin
                if (cnt == MID_LAST) begin
                    cap_mid    = 1'b1;
                    state_next = S_ON;
                end else if (strobe) begin
                    // symbol too short: restart the symbol from this sample
                    cap_prev = 1'b1;
                    cnt_clr  = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_ON: begin
                if (strobe) begin
                    launch     = 1'b1;
                    cap_prev   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_MID;
                end
            end
            default: state_next = S_INIT;
        endcase
    end

    // Exact Gardner product on sign-extended operands, then scale and clamp.
    always_comb begin
        mi_x   = {{(PW-WIDTH){mid_i[WIDTH-1]}}, mid_i};
        mq_x   = {{(PW-WIDTH){mid_q[WIDTH-1]}}, mid_q};
        di_x   = {{(PW-WIDTH-1){d_i[WIDTH]}}, d_i};
        dq_x   = {{(PW-WIDTH-1){d_q[WIDTH]}}, d_q};
        prod   = mi_x * di_x + mq_x * dq_x;
        e_wide = clamp_p(prod >>> (WIDTH - 1));
        e_next = e_wide[WIDTH-1:0];
    end

`ifdef GARDNER_TED_LOOP_FILTER_EN
    localparam int AW = WIDTH + ACC_EXT;
    localparam int FW = AW + 2;
    localparam logic signed [FW-1:0] ALIM = {{(FW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [FW-1:0] OLIM = {{(FW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};

    logic signed [AW-1:0]    acc, acc_new;
    logic signed [WIDTH-1:0] e_ki, e_kp, filt_out;
    logic signed [FW-1:0]    acc_sum, acc_sat, v, neg_sat;

    function automatic logic signed [FW-1:0] clamp_f(input logic signed [FW-1:0] x,
                                                     input logic signed [FW-1:0] lim);
        if (x > lim)
            return lim;
        else if (x < -lim)
            return -lim;
        else
            return x;
    endfunction

    always_comb begin
        e_ki     = e_reg >>> KI_SHIFT;
        e_kp     = e_reg >>> KP_SHIFT;
        acc_sum  = {{(FW-AW){acc[AW-1]}}, acc} + {{(FW-WIDTH){e_ki[WIDTH-1]}}, e_ki};
        acc_sat  = clamp_f(acc_sum, ALIM);
        acc_new  = acc_sat[AW-1:0];
        v        = {{(FW-WIDTH){e_kp[WIDTH-1]}}, e_kp} + acc_sat;
        neg_sat  = clamp_f(-v, OLIM);
        filt_out = neg_sat[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            error_n <= '0;
        end else if (v2) begin
            acc     <= acc_new;
            error_n <= filt_out;
        end
    end
`else
    // e is already clamped to +/-L, so its negation cannot overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            error_n <= '0;
        else if (v2)
            error_n <= -e_reg;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            cnt         <= '0;
            prev_i      <= '0;
            prev_q      <= '0;
            mid_i       <= '0;
            mid_q       <= '0;
            lp_i        <= '0;
            lp_q        <= '0;
            cur_i       <= '0;
            cur_q       <= '0;
            d_i         <= '0;
            d_q         <= '0;
            e_reg       <= '0;
            v0          <= 1'b0;
            v1          <= 1'b0;
            v2          <= 1'b0;
            error_valid <= 1'b0;
        end else begin
            state <= state_next;
            if (cnt_clr)
                cnt <= '0;
            else if (cnt_inc)
                cnt <= cnt + 1'b1;
            if (cap_prev) begin
                prev_i <= I_32M;
                prev_q <= Q_32M;
            end
            if (cap_mid) begin
                mid_i <= I_32M;
                mid_q <= Q_32M;
            end
            // prev is overwritten on the launch edge, so snapshot the old one
            v0 <= launch;
            if (launch) begin
                lp_i  <= prev_i;
                lp_q  <= prev_q;
                cur_i <= I_32M;
                cur_q <= Q_32M;
            end
            v1 <= v0;
            if (v0) begin
                d_i <= {lp_i[WIDTH-1], lp_i} - {cur_i[WIDTH-1], cur_i};
                d_q <= {lp_q[WIDTH-1], lp_q} - {cur_q[WIDTH-1], cur_q};
            end
            v2 <= v1;
            if (v1)
                e_reg <= e_next;
            error_valid <= v2;
        end
    end
endmodule
